imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the STACK_CPU instruction memory. Receives a program as a
//  byte stream (valid/ready), packs bytes big-endian into 32-bit instructions,
//  writes them to IM[0..N-1] through the memory write port, and verifies a
//  trailing XOR checksum. Holds the CPU in reset until a load completes
//  cleanly. Replaces hierarchical IM pokes for bring-up and benches.
// PARAMETERS
//  ADDR_W  7   IM address width; depth = 2**ADDR_W (128 words)
//  DATA_W  32  instruction width; fixed at 32 (4 bytes/word)
// PORTS
//  clock      in   1       single clock, all logic on posedge
//  reset      in   1       synchronous, active-low
//  start      in   1       1-cycle pulse: begin a load; ignored while busy
//  in_valid   in   1       byte stream valid
//  in_data    in   8       byte stream data
//  in_ready   out  1       byte accepted when in_valid & in_ready
//  im_we      out  1       IM write strobe, 1 cycle per word
//  im_addr    out  ADDR_W  IM write address
//  im_wdata   out  DATA_W  IM write data
//  cpu_reset  out  1       active-high reset to STACK_CPU; 1 = hold
//  busy       out  1       load in progress
//  done       out  1       sticky: last load passed; cleared by start
//  err        out  1       sticky: last load failed; cleared by start
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE; in_ready=0, im_we=0,
//    im_addr=0, im_wdata=0, busy=0, done=0, err=0, cpu_reset=1.
//  - Frame: COUNT byte N, then 4*N data bytes (MSB first per word),
//    then CHECK byte = XOR of all 4*N data bytes (COUNT byte not included).
//  - States: IDLE -start-> COUNT -> DATA -> CHECK -> DONE | ERR.
//    DONE/ERR -start-> COUNT. start in COUNT/DATA/CHECK is ignored.
//  - start (from any state except COUNT/DATA/CHECK): clear done/err,
//    cpu_reset=1, busy=1, word index=0, byte phase=0, checksum=0.
//  - in_ready=1 only in COUNT, DATA, CHECK; the stream may stall freely
//    (in_valid low) with no timeout.
//  - COUNT: N==0 -> CHECK (expect 0x00). N > 2**ADDR_W -> ERR.
//    Otherwise -> DATA.
//  - DATA: each accepted byte shifts into the packer and XORs into the
//    checksum. On the 4th byte of word k, im_we=1 on the next cycle with
//    im_addr=k and im_wdata=packed word. After word N-1 -> CHECK.
//    Back-to-back bytes give one write every 4 cycles; no lost bytes.
//  - CHECK: byte==checksum -> DONE, else -> ERR.
//  - DONE: busy=0, done=1, cpu_reset=0 one cycle after entry, i.e. after
//    the last im_we has retired.
//  - ERR: busy=0, err=1, cpu_reset stays 1. Partially written IM is not
//    rolled back.
//  - im_addr/im_wdata hold their last value when im_we=0.
//  - Reset mid-load: abort immediately; no im_we follows; all outputs
//    return to reset values.
//  - Word index is ADDR_W+1 bits so N==2**ADDR_W terminates without wrap.
// STRUCTURE
//  - stack_cpu_pkg: IM_ADDR_W, INSTR_W, loader state encodings
//    (IDLE, COUNT, DATA, CHECK, DONE, ERR).
//  - Sub-module imem_word_packer: 2-bit byte phase and 32-bit shift
//    register; emits word_valid plus word. Clear input is driven on start.
//  - Top level: FSM, word counter, checksum register, IM port registers.
// TESTING
//  1 Stream 03,04 00 00 00,08 00 00 00,0C 00 00 00,00 ->
//    IM[0..2]=0400_0000/0800_0000/0C00_0000; done=1; cpu_reset falls.
//  2 Same frame with checksum 0xFF -> err=1; cpu_reset stays 1; all three
//    words still written.
//  3 COUNT=0x81 (129) -> ERR right after the COUNT byte; no im_we.
//  4 in_valid toggling randomly during frame 1 -> identical writes/order.
//  5 reset low after 6 data bytes -> im_we never asserts again;
//    cpu_reset=1; a fresh start + frame 1 loads correctly.
//  6 COUNT=0x00, CHECK=0x00 -> done=1 with zero writes; start during DATA
//    ignored (no restart, word order unchanged).

Source files
------------

// File: rtl/stack_cpu_pkg.sv
// Shared STACK_CPU instruction-memory constants and loader state encodings.
package stack_cpu_pkg;

    localparam int IM_ADDR_W = 7;
    localparam int INSTR_W   = 32;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_COUNT = 3'd1,
        LD_DATA  = 3'd2,
        LD_CHECK = 3'd3,
        LD_DONE  = 3'd4,
        LD_ERR   = 3'd5
    } ld_state_t;

    // A frame is in flight; start is ignored in these states.
    function automatic logic ld_active(input ld_state_t s);
        return (s == LD_COUNT) || (s == LD_DATA) || (s == LD_CHECK);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs an MSB-first byte stream into 32-bit words; word_valid marks the 4th byte.
module imem_word_packer
    import stack_cpu_pkg::*;
#(
    parameter int DATA_W = INSTR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);

    logic [1:0]        phase_p0;
    logic [DATA_W-9:0] sr_p0;

    // The completed word includes the byte being accepted this cycle.
    assign word       = {sr_p0, byte_in};
    assign word_valid = shift_en && (phase_p0 == 2'd3);

    always_ff @(posedge clock) begin
        if (!reset) begin
            phase_p0 <= 2'd0;
        end else if (clear) begin
            phase_p0 <= 2'd0;
        end else if (shift_en) begin
            phase_p0 <= phase_p0 + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (shift_en) begin
            sr_p0 <= word[DATA_W-9:0];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a checksummed program into the instruction memory and holds the CPU
// in reset until a load completes cleanly.
module imem_loader
    import stack_cpu_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2**ADDR_W;

    ld_state_t         state;
    logic [ADDR_W:0]   nwords;
    logic [ADDR_W:0]   widx;
    logic [7:0]        csum;
    logic              accept;
    logic              start_ok;
    logic              shift_en;
    logic              word_valid;
    logic [DATA_W-1:0] word;

    assign accept   = in_valid & in_ready;
    assign start_ok = start & ~ld_active(state);
    assign shift_en = accept & (state == LD_DATA);

    imem_word_packer #(.DATA_W(DATA_W)) u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (start_ok),
        .shift_en   (shift_en),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= LD_IDLE;
            in_ready  <= 1'b0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            nwords    <= '0;
            widx      <= '0;
            csum      <= '0;
        end else begin
            im_we <= 1'b0;
            if (start_ok) begin
                state     <= LD_COUNT;
                in_ready  <= 1'b1;
                cpu_reset <= 1'b1;
                busy      <= 1'b1;
                done      <= 1'b0;
                err       <= 1'b0;
                widx      <= '0;
                csum      <= '0;
            end else begin
                case (state)
                    LD_COUNT: begin
                        if (accept) begin
                            if (in_data == 8'd0) begin
                                state <= LD_CHECK;
                            end else if (int'(in_data) > DEPTH) begin
                                state    <= LD_ERR;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                err      <= 1'b1;
                            end else begin
                                state  <= LD_DATA;
                                nwords <= (ADDR_W+1)'(in_data);
                            end
                        end
                    end
                    LD_DATA: begin
                        if (accept) begin
                            csum <= csum ^ in_data;
                            if (word_valid) begin
                                im_we    <= 1'b1;
                                im_addr  <= widx[ADDR_W-1:0];
                                im_wdata <= word;
                                widx     <= widx + 1'b1;
                                // widx is one bit wider than the address, so a full-depth load ends without wrap.
                                if (widx + 1'b1 == nwords) begin
                                    state <= LD_CHECK;
                                end
                            end
                        end
                    end
                    LD_CHECK: begin
                        if (accept) begin
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            if (in_data == csum) begin
                                state <= LD_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= LD_ERR;
                                err   <= 1'b1;
                            end
                        end
                    end
                    // Release the CPU one cycle after entry so the last write has retired.
                    LD_DONE: cpu_reset <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame loads, checksum/count errors, stalls, reset abort.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        im_we;
    logic [6:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.ADDR_W(7), .DATA_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    int          nchecks = 0;
    int          nerrs = 0;
    bit          gaps = 1'b0;
    logic [6:0]  wa[$];
    logic [31:0] wd[$];
    logic [7:0]  f1[12] = '{8'h04, 8'h00, 8'h00, 8'h00,
                            8'h08, 8'h00, 8'h00, 8'h00,
                            8'h0C, 8'h00, 8'h00, 8'h00};

    always @(negedge clock) begin
        if (im_we === 1'b1) begin
            wa.push_back(im_addr);
            wd.push_back(im_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clock);
    endtask

    task automatic frame1(input logic [7:0] ck);
        send(8'h03);
        for (int i = 0; i < 12; i++) send(f1[i]);
        send(ck);
    endtask

    task automatic check_frame1(input string p);
        check({p, "_nwr"}, 32'(wa.size()), 32'd3);
        check({p, "_a0"}, {25'd0, wa[0]}, 32'd0);
        check({p, "_d0"}, wd[0], 32'h0400_0000);
        check({p, "_a1"}, {25'd0, wa[1]}, 32'd1);
        check({p, "_d1"}, wd[1], 32'h0800_0000);
        check({p, "_a2"}, {25'd0, wa[2]}, 32'd2);
        check({p, "_d2"}, wd[2], 32'h0C00_0000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clock);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_im_we", {31'd0, im_we}, 32'd0);
        check("rst_im_addr", {25'd0, im_addr}, 32'd0);
        check("rst_im_wdata", im_wdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        reset = 1'b1;
        settle();
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // 1: clean three-word load
        pulse_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        send(8'h03);
        check("t1_cpu_reset_mid", {31'd0, cpu_reset}, 32'd1);
        for (int i = 0; i < 12; i++) send(f1[i]);
        send(8'h00);
        settle();
        check_frame1("t1");
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_err", {31'd0, err}, 32'd0);
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        check("t1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("t1_hold_addr", {25'd0, im_addr}, 32'd2);
        check("t1_hold_wdata", im_wdata, 32'h0C00_0000);

        // 2: bad checksum
        wa.delete(); wd.delete();
        pulse_start();
        check("t2_done_cleared", {31'd0, done}, 32'd0);
        check("t2_cpu_reset_start", {31'd0, cpu_reset}, 32'd1);
        frame1(8'hFF);
        settle();
        check_frame1("t2");
        check("t2_err", {31'd0, err}, 32'd1);
        check("t2_done", {31'd0, done}, 32'd0);
        check("t2_cpu_reset", {31'd0, cpu_reset}, 32'd1);

        // 3: count too large
        wa.delete(); wd.delete();
        pulse_start();
        check("t3_err_cleared", {31'd0, err}, 32'd0);
        send(8'h81);
        settle();
        check("t3_err", {31'd0, err}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_in_ready", {31'd0, in_ready}, 32'd0);
        check("t3_nwr", 32'(wa.size()), 32'd0);

        // Full-depth load: word k = {k, 00, 00, 01}, XOR over all bytes is 0
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h80);
        for (int k = 0; k < 128; k++) begin
            send(8'(k)); send(8'h00); send(8'h00); send(8'h01);
        end
        send(8'h00);
        settle();
        check("full_nwr", 32'(wa.size()), 32'd128);
        check("full_d0", wd[0], 32'h0000_0001);
        check("full_a127", {25'd0, wa[127]}, 32'd127);
        check("full_d127", wd[127], 32'h7F00_0001);
        check("full_done", {31'd0, done}, 32'd1);

        // 4: stalled stream
        wa.delete(); wd.delete();
        gaps = 1'b1;
        pulse_start();
        frame1(8'h00);
        gaps = 1'b0;
        settle();
        check_frame1("t4");
        check("t4_done", {31'd0, done}, 32'd1);

        // 5: reset mid-load, then a fresh load
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h03);
        for (int i = 0; i < 6; i++) send(f1[i]);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("t5_nwr_abort", 32'(wa.size()), 32'd1);
        check("t5_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_in_ready", {31'd0, in_ready}, 32'd0);
        check("t5_im_wdata", im_wdata, 32'd0);
        wa.delete(); wd.delete();
        pulse_start();
        frame1(8'h00);
        settle();
        check_frame1("t5");
        check("t5_done", {31'd0, done}, 32'd1);

        // 6: empty program, then start ignored during DATA
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h00);
        send(8'h00);
        settle();
        check("t6_done_empty", {31'd0, done}, 32'd1);
        check("t6_nwr_empty", 32'(wa.size()), 32'd0);
        check("t6_cpu_reset_empty", {31'd0, cpu_reset}, 32'd0);
        pulse_start();
        send(8'h03);
        send(f1[0]);
        send(f1[1]);
        pulse_start();
        check("t6_busy_ignored", {31'd0, busy}, 32'd1);
        for (int i = 2; i < 12; i++) send(f1[i]);
        send(8'h00);
        settle();
        check_frame1("t6");
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_err", {31'd0, err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end

endmodule
